uart_rx: RTL

Parametrised UART receiver that replaces the single-byte receiver feeding the core's program loader. It oversamples the synchronised serial line at a configurable clocks-per-bit rate and supports a configurable data width. It detects glitched start bits and framing errors. Received words are buffered in a small show-ahead FIFO, so the consumer (the core's RECV state) pops words with a valid/ready handshake instead of edge-detecting a level READY flag.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 66 ++++++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state type and default bit timing.
package uart_pkg;

  // 100 MHz system clock / 9600 baud.
  localparam int UART_DEFAULT_CLKS_PER_BIT = 10417;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO. rdata is a register that always holds the head
// entry, so it changes only in the cycle after a pop or after the first write
// into an empty FIFO.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    after_pop;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign rd_next   = rd_ptr + AW'(do_pop);
  assign after_pop = count - CW'(do_pop);

  // Storage write.
  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are meaningful, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_next;
      count <= count + CW'(do_push) - CW'(do_pop);
      // The next head is either the word being written (when nothing else
      // remains) or the stored entry at the advanced read pointer.
      if (do_push && after_pop == '0) begin
        rdata <= wdata;
      end else if (after_pop != '0) begin
        rdata <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with glitch rejection, framing-error detection,
// break handling and a show-ahead receive FIFO popped with VALID/READY.
// Optional even parity is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          UART_RXD,
  output logic [DATA_BITS-1:0]          DATA,
  output logic                          VALID,
  input  logic                          READY,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          FRAME_ERR,
  output logic                          PARITY_ERR,
  output logic                          OVERRUN
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  uart_rx_state_t         state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   push_q;
  logic                   frame_err;
  logic                   overrun;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad;
  logic                   parity_err;
`endif

  assign rxs = sync[SYNC_STAGES-1];

  // Synchroniser for the asynchronous line; resets to the idle (high) level.
  // NOTE: registers are updated with <= so every stage samples the previous
  // stage's old value at the same edge, giving a true shift chain.
  always_ff @(posedge CLK) begin
    if (RST) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], UART_RXD};
  end

  // Receive FSM: baud counter, bit sampling, shift register and error pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      push_q    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rxs) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            // A line that is already high again mid start bit was a glitch.
            state <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bad <= (rxs != ^shreg);
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rxs) begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end else begin
`ifdef UART_RX_PARITY_EN
              if (par_bad) parity_err <= 1'b1;
              else         push_q     <= 1'b1;
`else
              push_q <= 1'b1;
`endif
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          // Hold off until the line returns high so a stuck-low line is not
          // decoded as a stream of zero words.
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign VALID = !fifo_empty;
  assign pop   = VALID && READY;

  // Overrun pulse: a completed word met a full FIFO with no pop to make room.
  always_ff @(posedge CLK) begin
    if (RST) overrun <= 1'b0;
    else     overrun <= push_q && fifo_full && !pop;
  end

  // shreg stays stable until the next frame's data bits, so it can feed the
  // FIFO directly in the cycle after the stop-bit sample.
  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_q),
    .pop   (pop),
    .wdata (shreg),
    .rdata (DATA),
    .count (COUNT),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign FRAME_ERR = frame_err;
  assign OVERRUN   = overrun;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = parity_err;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule
